// File: rtl/axi_pkg.sv
// AXI channel structs shared by cpus, memory and the round-robin mux,
// plus the mux FSM state type and grant-index width helper.
package axi_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_aw_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} mux_state_e;

  // A single cpu still needs a 1-bit index so grant registers never collapse to zero width.
  function automatic int cpu_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above i_ptr,
// wrapping at N.
module rr_arbiter
  import axi_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = cpu_idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_gnt_any
);

  always_comb begin
    int w_idx;
    w_idx     = 0;
    o_gnt_any = 1'b0;
    o_gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_gnt_any && i_req[w_idx]) begin
        o_gnt_any = 1'b1;
        o_gnt_idx = w_idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_rr_mux.sv
// N:1 AXI round-robin mux, one outstanding transaction per direction,
// independent read/write paths. Optional grant counters: AXI_RR_MUX_STATS_EN.
module axi_rr_mux
  import axi_pkg::*;
#(
  parameter int CPU_NB = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  axi_aw_t [CPU_NB-1:0]  i_axi_s_aw,
  output logic    [CPU_NB-1:0]  o_axi_s_awready,
  input  logic    [CPU_NB-1:0]  i_axi_s_awvalid,
  input  axi_w_t  [CPU_NB-1:0]  i_axi_s_w,
  output logic    [CPU_NB-1:0]  o_axi_s_wready,
  input  logic    [CPU_NB-1:0]  i_axi_s_wvalid,
  output axi_b_t  [CPU_NB-1:0]  o_axi_s_b,
  input  logic    [CPU_NB-1:0]  i_axi_s_bready,
  output logic    [CPU_NB-1:0]  o_axi_s_bvalid,
  input  axi_ar_t [CPU_NB-1:0]  i_axi_s_ar,
  output logic    [CPU_NB-1:0]  o_axi_s_arready,
  input  logic    [CPU_NB-1:0]  i_axi_s_arvalid,
  output axi_r_t  [CPU_NB-1:0]  o_axi_s_r,
  input  logic    [CPU_NB-1:0]  i_axi_s_rready,
  output logic    [CPU_NB-1:0]  o_axi_s_rvalid,
  output axi_aw_t               o_axi_m_aw,
  input  logic                  i_axi_m_awready,
  output logic                  o_axi_m_awvalid,
  output axi_w_t                o_axi_m_w,
  input  logic                  i_axi_m_wready,
  output logic                  o_axi_m_wvalid,
  input  axi_b_t                i_axi_m_b,
  output logic                  o_axi_m_bready,
  input  logic                  i_axi_m_bvalid,
  output axi_ar_t               o_axi_m_ar,
  input  logic                  i_axi_m_arready,
  output logic                  o_axi_m_arvalid,
  input  axi_r_t                i_axi_m_r,
  output logic                  o_axi_m_rready,
  input  logic                  i_axi_m_rvalid
`ifdef AXI_RR_MUX_STATS_EN
  ,
  output logic [CPU_NB-1:0][31:0] o_grant_cnt
`endif
);

  localparam int IW = cpu_idx_w(CPU_NB);

  mux_state_e    r_wst, w_wst_nxt, r_rst, w_rst_nxt;
  logic [IW-1:0] r_wptr, r_rptr, r_wg, r_rg;
  logic [IW-1:0] w_aw_idx, w_ar_idx;
  logic          w_aw_any, w_ar_any;
  logic          w_b_done, w_r_done;

  function automatic logic [IW-1:0] f_next(input logic [IW-1:0] g);
    if (int'(g) >= CPU_NB - 1) return '0;
    return g + 1'b1;
  endfunction

  rr_arbiter #(.N(CPU_NB)) u_aw_arb (
    .i_req(i_axi_s_awvalid), .i_ptr(r_wptr), .o_gnt_idx(w_aw_idx), .o_gnt_any(w_aw_any)
  );

  rr_arbiter #(.N(CPU_NB)) u_ar_arb (
    .i_req(i_axi_s_arvalid), .i_ptr(r_rptr), .o_gnt_idx(w_ar_idx), .o_gnt_any(w_ar_any)
  );

  assign w_b_done = !rst && (r_wst == RESP) && i_axi_m_bvalid && i_axi_s_bready[r_wg];
  assign w_r_done = !rst && (r_rst == DATA) && i_axi_m_rvalid && i_axi_s_rready[r_rg]
                    && i_axi_m_r.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wst  <= IDLE;
      r_rst  <= IDLE;
      r_wptr <= '0;
      r_rptr <= '0;
      r_wg   <= '0;
      r_rg   <= '0;
    end else begin
      r_wst <= w_wst_nxt;
      r_rst <= w_rst_nxt;
      if (r_wst == IDLE && w_aw_any) r_wg <= w_aw_idx;
      if (r_rst == IDLE && w_ar_any) r_rg <= w_ar_idx;
      if (w_b_done) r_wptr <= f_next(r_wg);
      if (w_r_done) r_rptr <= f_next(r_rg);
    end
  end

  // Write path; everything is gated by rst so outputs are quiet for the whole reset.
  always_comb begin
    w_wst_nxt       = r_wst;
    o_axi_s_awready = '0;
    o_axi_s_wready  = '0;
    o_axi_s_bvalid  = '0;
    o_axi_s_b       = '0;
    o_axi_m_aw      = '0;
    o_axi_m_awvalid = 1'b0;
    o_axi_m_w       = '0;
    o_axi_m_wvalid  = 1'b0;
    o_axi_m_bready  = 1'b0;
    if (!rst) begin
      unique case (r_wst)
        IDLE: if (w_aw_any) w_wst_nxt = ADDR;
        ADDR: begin
          o_axi_m_awvalid       = 1'b1;
          o_axi_m_aw            = i_axi_s_aw[r_wg];
          o_axi_s_awready[r_wg] = i_axi_m_awready;
          if (i_axi_m_awready) w_wst_nxt = DATA;
        end
        DATA: begin
          o_axi_m_wvalid       = i_axi_s_wvalid[r_wg];
          o_axi_m_w            = i_axi_s_w[r_wg];
          o_axi_s_wready[r_wg] = i_axi_m_wready;
          if (i_axi_s_wvalid[r_wg] && i_axi_m_wready && i_axi_s_w[r_wg].last)
            w_wst_nxt = RESP;
        end
        RESP: begin
          o_axi_s_bvalid[r_wg] = i_axi_m_bvalid;
          o_axi_s_b[r_wg]      = i_axi_m_b;
          o_axi_m_bready       = i_axi_s_bready[r_wg];
          if (w_b_done) w_wst_nxt = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_rst_nxt       = r_rst;
    o_axi_s_arready = '0;
    o_axi_s_rvalid  = '0;
    o_axi_s_r       = '0;
    o_axi_m_ar      = '0;
    o_axi_m_arvalid = 1'b0;
    o_axi_m_rready  = 1'b0;
    if (!rst) begin
      unique case (r_rst)
        IDLE: if (w_ar_any) w_rst_nxt = ADDR;
        ADDR: begin
          o_axi_m_arvalid       = 1'b1;
          o_axi_m_ar            = i_axi_s_ar[r_rg];
          o_axi_s_arready[r_rg] = i_axi_m_arready;
          if (i_axi_m_arready) w_rst_nxt = DATA;
        end
        DATA: begin
          o_axi_s_rvalid[r_rg] = i_axi_m_rvalid;
          o_axi_s_r[r_rg]      = i_axi_m_r;
          o_axi_m_rready       = i_axi_s_rready[r_rg];
          if (w_r_done) w_rst_nxt = IDLE;
        end
        default: w_rst_nxt = IDLE;
      endcase
    end
  end

`ifdef AXI_RR_MUX_STATS_EN
  logic [CPU_NB-1:0][31:0] r_grant_cnt, w_cnt_nxt;
  logic [1:0]              w_inc;
  logic [32:0]             w_sum;

  // A cpu finishing a read and a write in the same cycle counts twice.
  always_comb begin
    w_cnt_nxt = r_grant_cnt;
    w_inc     = '0;
    w_sum     = '0;
    for (int i = 0; i < CPU_NB; i++) begin
      w_inc = {1'b0, w_b_done && (r_wg == IW'(i))} + {1'b0, w_r_done && (r_rg == IW'(i))};
      w_sum = {1'b0, r_grant_cnt[i]} + {31'd0, w_inc};
      w_cnt_nxt[i] = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_grant_cnt <= '0;
    else     r_grant_cnt <= w_cnt_nxt;
  end

  assign o_grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_axi_rr_mux.sv
// Directed bench for axi_rr_mux: reset, single write, read fairness, write burst,
// read/write concurrency, mid-transfer reset, and grant counters when enabled.
module tb_axi_rr_mux;
  import axi_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_aw_t [N-1:0] i_axi_s_aw;
  logic    [N-1:0] o_axi_s_awready, i_axi_s_awvalid;
  axi_w_t  [N-1:0] i_axi_s_w;
  logic    [N-1:0] o_axi_s_wready, i_axi_s_wvalid;
  axi_b_t  [N-1:0] o_axi_s_b;
  logic    [N-1:0] i_axi_s_bready, o_axi_s_bvalid;
  axi_ar_t [N-1:0] i_axi_s_ar;
  logic    [N-1:0] o_axi_s_arready, i_axi_s_arvalid;
  axi_r_t  [N-1:0] o_axi_s_r;
  logic    [N-1:0] i_axi_s_rready, o_axi_s_rvalid;
  axi_aw_t o_axi_m_aw;
  logic    i_axi_m_awready, o_axi_m_awvalid;
  axi_w_t  o_axi_m_w;
  logic    i_axi_m_wready, o_axi_m_wvalid;
  axi_b_t  i_axi_m_b;
  logic    o_axi_m_bready, i_axi_m_bvalid;
  axi_ar_t o_axi_m_ar;
  logic    i_axi_m_arready, o_axi_m_arvalid;
  axi_r_t  i_axi_m_r;
  logic    o_axi_m_rready, i_axi_m_rvalid;
`ifdef AXI_RR_MUX_STATS_EN
  logic [N-1:0][31:0] o_grant_cnt;
`endif

  int checks = 0;
  int errs   = 0;

  axi_rr_mux #(.CPU_NB(N)) dut (
    .clk(clk), .rst(rst),
    .i_axi_s_aw(i_axi_s_aw), .o_axi_s_awready(o_axi_s_awready), .i_axi_s_awvalid(i_axi_s_awvalid),
    .i_axi_s_w(i_axi_s_w), .o_axi_s_wready(o_axi_s_wready), .i_axi_s_wvalid(i_axi_s_wvalid),
    .o_axi_s_b(o_axi_s_b), .i_axi_s_bready(i_axi_s_bready), .o_axi_s_bvalid(o_axi_s_bvalid),
    .i_axi_s_ar(i_axi_s_ar), .o_axi_s_arready(o_axi_s_arready), .i_axi_s_arvalid(i_axi_s_arvalid),
    .o_axi_s_r(o_axi_s_r), .i_axi_s_rready(i_axi_s_rready), .o_axi_s_rvalid(o_axi_s_rvalid),
    .o_axi_m_aw(o_axi_m_aw), .i_axi_m_awready(i_axi_m_awready), .o_axi_m_awvalid(o_axi_m_awvalid),
    .o_axi_m_w(o_axi_m_w), .i_axi_m_wready(i_axi_m_wready), .o_axi_m_wvalid(o_axi_m_wvalid),
    .i_axi_m_b(i_axi_m_b), .o_axi_m_bready(o_axi_m_bready), .i_axi_m_bvalid(i_axi_m_bvalid),
    .o_axi_m_ar(o_axi_m_ar), .i_axi_m_arready(i_axi_m_arready), .o_axi_m_arvalid(o_axi_m_arvalid),
    .i_axi_m_r(i_axi_m_r), .o_axi_m_rready(o_axi_m_rready), .i_axi_m_rvalid(i_axi_m_rvalid)
`ifdef AXI_RR_MUX_STATS_EN
    , .o_grant_cnt(o_grant_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_axi_s_aw = '0; i_axi_s_awvalid = '0;
    i_axi_s_w  = '0; i_axi_s_wvalid  = '0;
    i_axi_s_ar = '0; i_axi_s_arvalid = '0;
    i_axi_s_bready = '1; i_axi_s_rready = '1;
    i_axi_m_awready = 1'b1; i_axi_m_wready = 1'b1; i_axi_m_arready = 1'b1;
    i_axi_m_b = '0; i_axi_m_bvalid = 1'b0;
    i_axi_m_r = '0; i_axi_m_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Full single-beat write from IDLE, port p alone requesting.
  task automatic do_write(input int p);
    i_axi_s_awvalid[p] = 1'b1;
    tick();
    tick();
    i_axi_s_awvalid[p] = 1'b0;
    i_axi_s_w[p].last = 1'b1;
    i_axi_s_wvalid[p] = 1'b1;
    tick();
    i_axi_s_wvalid[p] = 1'b0;
    i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
  endtask

  task automatic do_read(input int p);
    i_axi_s_arvalid[p] = 1'b1;
    tick();
    tick();
    i_axi_s_arvalid[p] = 1'b0;
    i_axi_m_r.last = 1'b1;
    i_axi_m_rvalid = 1'b1;
    tick();
    i_axi_m_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr();
    i_axi_s_awvalid = '1; i_axi_s_arvalid = '1;
    i_axi_m_bvalid = 1'b1; i_axi_m_rvalid = 1'b1;
    i_axi_s_aw[0].addr = 32'h1234;
    tick();
    tick();
    checks++; if (o_axi_m_awvalid !== 1'b0 || o_axi_m_arvalid !== 1'b0) begin errs++;
      $display("FAIL rst_m_valid aw=%b ar=%b exp=0", o_axi_m_awvalid, o_axi_m_arvalid); end
    checks++; if (o_axi_s_awready !== 4'b0 || o_axi_s_arready !== 4'b0) begin errs++;
      $display("FAIL rst_s_ready aw=%b ar=%b exp=0", o_axi_s_awready, o_axi_s_arready); end
    checks++; if (o_axi_s_bvalid !== 4'b0 || o_axi_s_rvalid !== 4'b0) begin errs++;
      $display("FAIL rst_s_valid b=%b r=%b exp=0", o_axi_s_bvalid, o_axi_s_rvalid); end
    checks++; if (o_axi_m_bready !== 1'b0 || o_axi_m_rready !== 1'b0 || o_axi_m_aw !== '0) begin errs++;
      $display("FAIL rst_m_ready_payload bready=%b rready=%b aw=%h exp=0", o_axi_m_bready, o_axi_m_rready, o_axi_m_aw); end
    clr();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    i_axi_s_aw[2].addr = 32'h40;
    i_axi_s_aw[2].len  = 8'd0;
    i_axi_s_awvalid[2] = 1'b1;
    #1;
    checks++; if (o_axi_m_awvalid !== 1'b0) begin errs++;
      $display("FAIL wr_idle_awvalid got=%b exp=0", o_axi_m_awvalid); end
    tick();
    checks++; if (o_axi_m_awvalid !== 1'b1 || o_axi_m_aw.addr !== 32'h40) begin errs++;
      $display("FAIL wr_aw got_v=%b got_addr=%h exp_v=1 exp_addr=40", o_axi_m_awvalid, o_axi_m_aw.addr); end
    checks++; if (o_axi_s_awready !== 4'b0100) begin errs++;
      $display("FAIL wr_awready got=%b exp=0100", o_axi_s_awready); end
    tick();
    i_axi_s_awvalid[2] = 1'b0;
    i_axi_s_w[2].data = 32'hDEAD;
    i_axi_s_w[2].last = 1'b1;
    i_axi_s_wvalid[2] = 1'b1;
    #1;
    checks++; if (o_axi_m_wvalid !== 1'b1 || o_axi_m_w.data !== 32'hDEAD || o_axi_s_wready !== 4'b0100) begin errs++;
      $display("FAIL wr_w got_v=%b data=%h wready=%b exp 1/dead/0100", o_axi_m_wvalid, o_axi_m_w.data, o_axi_s_wready); end
    tick();
    i_axi_s_wvalid[2] = 1'b0;
    i_axi_m_b.resp = 2'b00;
    i_axi_m_bvalid = 1'b1;
    #1;
    checks++; if (o_axi_s_bvalid !== 4'b0100 || o_axi_m_bready !== 1'b1) begin errs++;
      $display("FAIL wr_b got_bvalid=%b bready=%b exp 0100/1", o_axi_s_bvalid, o_axi_m_bready); end
    tick();
    i_axi_m_bvalid = 1'b0;
    // pointer should now be 3: cpu3 wins over cpu2
    i_axi_s_awvalid[2] = 1'b1;
    i_axi_s_awvalid[3] = 1'b1;
    tick();
    checks++; if (o_axi_s_awready !== 4'b1000) begin errs++;
      $display("FAIL wr_ptr3 got=%b exp=1000", o_axi_s_awready); end
    tick();
    i_axi_s_awvalid[3] = 1'b0;
    i_axi_s_w[3].last = 1'b1;
    i_axi_s_wvalid[3] = 1'b1;
    tick();
    i_axi_s_wvalid[3] = 1'b0;
    i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
    tick();
    checks++; if (o_axi_s_awready !== 4'b0100) begin errs++;
      $display("FAIL wr_wrap_cpu2 got=%b exp=0100", o_axi_s_awready); end
    tick();
    i_axi_s_awvalid[2] = 1'b0;
    i_axi_s_wvalid[2] = 1'b1;
    tick();
    i_axi_s_wvalid[2] = 1'b0;
    i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
  endtask

  task automatic test_fairness();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    i_axi_s_arvalid = '1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (o_axi_s_arready !== (4'b0001 << exp_g[k])) begin errs++;
        $display("FAIL rd_fair_grant%0d got=%b exp_idx=%0d", k, o_axi_s_arready, exp_g[k]); end
      tick();
      i_axi_m_r.data = 32'h500 + k;
      i_axi_m_r.last = 1'b1;
      i_axi_m_rvalid = 1'b1;
      #1;
      checks++; if (o_axi_s_rvalid !== (4'b0001 << exp_g[k]) || o_axi_s_r[exp_g[k]].data !== 32'h500 + k) begin errs++;
        $display("FAIL rd_fair_r%0d got_v=%b data=%h", k, o_axi_s_rvalid, o_axi_s_r[exp_g[k]].data); end
      tick();
      i_axi_m_rvalid = 1'b0;
    end
    i_axi_s_arvalid = '0;
  endtask

  task automatic test_burst();
    i_axi_s_aw[1].len = 8'd3;
    i_axi_s_awvalid[1] = 1'b1;
    tick();
    i_axi_s_awvalid[0] = 1'b1;
    i_axi_s_w[1].data = 32'h100;
    i_axi_s_w[1].last = 1'b0;
    i_axi_s_wvalid[1] = 1'b1;
    #1;
    checks++; if (o_axi_s_awready !== 4'b0010) begin errs++;
      $display("FAIL bu_awready got=%b exp=0010", o_axi_s_awready); end
    checks++; if (o_axi_s_wready !== 4'b0000 || o_axi_m_wvalid !== 1'b0) begin errs++;
      $display("FAIL bu_w_in_addr wready=%b wvalid=%b exp 0/0", o_axi_s_wready, o_axi_m_wvalid); end
    tick();
    i_axi_s_awvalid[1] = 1'b0;
    i_axi_m_bvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      i_axi_s_w[1].data = 32'h100 + b;
      i_axi_s_w[1].last = (b == 3);
      #1;
      checks++; if (o_axi_m_wvalid !== 1'b1 || o_axi_m_w.data !== 32'h100 + b || o_axi_s_wready !== 4'b0010) begin errs++;
        $display("FAIL bu_beat%0d v=%b data=%h wready=%b", b, o_axi_m_wvalid, o_axi_m_w.data, o_axi_s_wready); end
      checks++; if (o_axi_s_awready !== 4'b0000 || o_axi_m_bready !== 1'b0 || o_axi_s_bvalid !== 4'b0000) begin errs++;
        $display("FAIL bu_stall%0d awready=%b bready=%b bvalid=%b exp 0", b, o_axi_s_awready, o_axi_m_bready, o_axi_s_bvalid); end
      tick();
    end
    i_axi_s_wvalid[1] = 1'b0;
    #1;
    checks++; if (o_axi_s_bvalid !== 4'b0010) begin errs++;
      $display("FAIL bu_b got=%b exp=0010", o_axi_s_bvalid); end
    tick();
    i_axi_m_bvalid = 1'b0;
    tick();
    checks++; if (o_axi_s_awready !== 4'b0001) begin errs++;
      $display("FAIL bu_cpu0_next got=%b exp=0001", o_axi_s_awready); end
    tick();
    i_axi_s_awvalid[0] = 1'b0;
    i_axi_s_w[0].last = 1'b1;
    i_axi_s_wvalid[0] = 1'b1;
    tick();
    i_axi_s_wvalid[0] = 1'b0;
    i_axi_m_bvalid = 1'b1;
    tick();
    i_axi_m_bvalid = 1'b0;
  endtask

  task automatic test_concurrency();
    i_axi_s_arvalid[0] = 1'b1;
    i_axi_s_awvalid[3] = 1'b1;
    tick();
    checks++; if (o_axi_m_awvalid !== 1'b1 || o_axi_m_arvalid !== 1'b1) begin errs++;
      $display("FAIL cc_valids aw=%b ar=%b exp 1/1", o_axi_m_awvalid, o_axi_m_arvalid); end
    checks++; if (o_axi_s_awready !== 4'b1000 || o_axi_s_arready !== 4'b0001) begin errs++;
      $display("FAIL cc_readies aw=%b ar=%b exp 1000/0001", o_axi_s_awready, o_axi_s_arready); end
    tick();
    i_axi_s_arvalid[0] = 1'b0;
    i_axi_s_awvalid[3] = 1'b0;
    i_axi_s_w[3].last = 1'b1;
    i_axi_s_wvalid[3] = 1'b1;
    i_axi_m_r.data = 32'hBEEF;
    i_axi_m_r.last = 1'b1;
    i_axi_m_rvalid = 1'b1;
    #1;
    checks++; if (o_axi_s_rvalid !== 4'b0001 || o_axi_s_r[0].data !== 32'hBEEF || o_axi_m_wvalid !== 1'b1) begin errs++;
      $display("FAIL cc_r rvalid=%b data=%h wvalid=%b exp 0001/beef/1", o_axi_s_rvalid, o_axi_s_r[0].data, o_axi_m_wvalid); end
    tick();
    i_axi_s_wvalid[3] = 1'b0;
    i_axi_m_rvalid = 1'b0;
    i_axi_m_b.resp = 2'b01;
    i_axi_m_bvalid = 1'b1;
    #1;
    checks++; if (o_axi_s_bvalid !== 4'b1000 || o_axi_s_b[3].resp !== 2'b01) begin errs++;
      $display("FAIL cc_b bvalid=%b resp=%b exp 1000/01", o_axi_s_bvalid, o_axi_s_b[3].resp); end
    tick();
    i_axi_m_bvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_axi_s_arvalid[1] = 1'b1;
    tick();
    tick();
    i_axi_s_arvalid[1] = 1'b0;
    i_axi_m_r.last = 1'b0;
    i_axi_m_rvalid = 1'b1;
    for (int b = 0; b < 2; b++) begin
      i_axi_m_r.data = b;
      tick();
    end
    #1;
    checks++; if (o_axi_s_rvalid !== 4'b0010) begin errs++;
      $display("FAIL rm_beat3 got=%b exp=0010", o_axi_s_rvalid); end
    rst = 1'b1;
    tick();
    checks++; if (o_axi_s_rvalid !== 4'b0 || o_axi_m_rready !== 1'b0 || o_axi_m_arvalid !== 1'b0) begin errs++;
      $display("FAIL rm_abort rvalid=%b rready=%b arvalid=%b exp 0", o_axi_s_rvalid, o_axi_m_rready, o_axi_m_arvalid); end
    rst = 1'b0;
    #1;
    checks++; if (o_axi_s_rvalid !== 4'b0 || o_axi_m_rready !== 1'b0) begin errs++;
      $display("FAIL rm_stray_r rvalid=%b rready=%b exp 0", o_axi_s_rvalid, o_axi_m_rready); end
    i_axi_m_rvalid = 1'b0;
    i_axi_s_arvalid[2:0] = 3'b111;
    tick();
    checks++; if (o_axi_s_arready !== 4'b0001) begin errs++;
      $display("FAIL rm_ptr0 got=%b exp=0001", o_axi_s_arready); end
    do_reset();
  endtask

`ifdef AXI_RR_MUX_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 3; k++) do_write(1);
    for (int k = 0; k < 2; k++) do_read(1);
    for (int i = 0; i < N; i++) begin
      checks++; if (o_grant_cnt[i] !== ((i == 1) ? 32'd5 : 32'd0)) begin errs++;
        $display("FAIL st_cnt%0d got=%0d exp=%0d", i, o_grant_cnt[i], (i == 1) ? 5 : 0); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clr();
    test_reset();
    test_single_write();
    test_fairness();
    test_burst();
    test_concurrency();
    test_reset_mid();
`ifdef AXI_RR_MUX_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/axi_rr_mux.md
Name: axi_rr_mux

Overview:
- N:1 AXI manager-side multiplexer between the CPU_NB cpu instances and a single-port memory subordinate.
- Round-robin arbitration with one outstanding transaction per direction.
- Read path (AR/R) and write path (AW/W/B) are fully independent.
- Reuses the axi_pkg channel structs unchanged, so it drops in upstream of a single-port memory.

Parameters:
CPU_NB, 4, number of subordinate-side ports (cpu managers); legal range 1..16

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_axi_s_aw  in  axi_aw_t[CPU_NB]  AW payload per cpu
o_axi_s_awready  out  bit[CPU_NB]  AW ready per cpu
i_axi_s_awvalid  in  bit[CPU_NB]  AW valid per cpu
i_axi_s_w  in  axi_w_t[CPU_NB]  W payload per cpu; field last marks final beat
o_axi_s_wready  out  bit[CPU_NB]  W ready per cpu
i_axi_s_wvalid  in  bit[CPU_NB]  W valid per cpu
o_axi_s_b  out  axi_b_t[CPU_NB]  B payload per cpu
i_axi_s_bready  in  bit[CPU_NB]  B ready per cpu
o_axi_s_bvalid  out  bit[CPU_NB]  B valid per cpu
i_axi_s_ar  in  axi_ar_t[CPU_NB]  AR payload per cpu
o_axi_s_arready  out  bit[CPU_NB]  AR ready per cpu
i_axi_s_arvalid  in  bit[CPU_NB]  AR valid per cpu
o_axi_s_r  out  axi_r_t[CPU_NB]  R payload per cpu; field last marks final beat
i_axi_s_rready  in  bit[CPU_NB]  R ready per cpu
o_axi_s_rvalid  out  bit[CPU_NB]  R valid per cpu
o_axi_m_aw / i_axi_m_awready / o_axi_m_awvalid  out/in/out  axi_aw_t/1/1  downstream AW
o_axi_m_w / i_axi_m_wready / o_axi_m_wvalid  out/in/out  axi_w_t/1/1  downstream W
i_axi_m_b / o_axi_m_bready / i_axi_m_bvalid  in/out/in  axi_b_t/1/1  downstream B
o_axi_m_ar / i_axi_m_arready / o_axi_m_arvalid  out/in/out  axi_ar_t/1/1  downstream AR
i_axi_m_r / o_axi_m_rready / i_axi_m_rvalid  in/out/in  axi_r_t/1/1  downstream R

Behaviour:
- One clock, clk.
- rst is synchronous, active-high. While rst is high:
  - both FSMs go to IDLE;
  - both rr pointers go to 0;
  - all valid and ready outputs are 0;
  - payload outputs are '0.
- Write FSM states and transitions:
  - IDLE: arbiter examines i_axi_s_awvalid and registers the grant index. Moves to ADDR on the next edge if any valid is set; otherwise stays in IDLE.
  - ADDR: o_axi_m_awvalid=1 and o_axi_m_aw=i_axi_s_aw[g]; o_axi_s_awready[g]=i_axi_m_awready. On the AW handshake, moves to DATA.
  - DATA: W is routed combinationally between port g and the downstream W. On a handshake with w.last=1, moves to RESP.
  - RESP: B is routed downstream->g. On the B handshake, moves to IDLE and sets pointer = (g+1) mod CPU_NB.
- Read FSM states and transitions:
  - IDLE: arbiter examines i_axi_s_arvalid and registers the grant.
  - ADDR: AR handshake as for AW.
  - DATA: R is routed to g. On a handshake with r.last=1, moves to IDLE and sets pointer = (g+1) mod CPU_NB.
- Arbitration: the first asserted valid found searching upward from the pointer, wrapping at CPU_NB.
- Latency:
  - A valid that is high in IDLE at edge n gives downstream valid at n+1.
  - Minimum AW-to-next-AW spacing is 4 cycles for a single-beat write.
  - W, B and R are zero-latency pass-through.
- Non-granted ports see ready=0 and valid=0 on every channel. A cpu must hold its AW/AR valid until it is granted.
- W beats presented by g while in ADDR are not accepted (wready=0 until DATA).
- Reads and writes may be granted in the same cycle, to the same or different cpus.
- Only one valid in IDLE: that cpu is granted regardless of the pointer.
- CPU_NB=1: index width is 1; the pointer stays at 0.
- Downstream B or R arriving in IDLE/ADDR is a protocol error: bready/rready stay 0 (no drop).
- rst mid-transaction aborts the transfer: outputs drop the same edge and the pointer returns to 0.

Optional Feature:
- Macro AXI_RR_MUX_STATS_EN.
- When defined:
  - adds output o_grant_cnt, type bit[31:0][CPU_NB];
  - entry i increments on each completed write or read transaction of cpu i (increments by 2 if both complete in the same cycle);
  - counters saturate at 32'hFFFF_FFFF and are cleared by rst.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- axi_pkg gains:
  - localparam CPU_IDX_W function (max(1,$clog2(n)));
  - typedef enum mux_state_e {IDLE, ADDR, DATA, RESP}.
- Sub-module rr_arbiter (parameter N; inputs req[N] and ptr; outputs gnt_idx and gnt_any; purely combinational).
- rr_arbiter is instantiated twice, once for AW and once for AR; pointers and FSMs stay in axi_rr_mux.

Test Plan:
- Single write: cpu2 sends AW addr 0x40, len 0, one W beat 0xDEAD with last=1; memory returns B okay. Expected: o_axi_m_awvalid rises 1 cycle after cpu2's awvalid, o_axi_m_aw.addr=0x40, bvalid appears only on port 2, pointer becomes 3.
- Fairness: all 4 cpus hold arvalid continuously with single-beat reads. Expected grant order 0,1,2,3,0; no cpu is granted twice before every other cpu is granted once.
- Burst: cpu1 issues a 4-beat write. Expected: all 4 W beats forwarded in order; RESP is entered only after the beat with last=1; cpu0's pending AW stays stalled (awready=0) throughout.
- Concurrency: in the same cycle cpu0 issues an AR and cpu3 issues an AW. Expected: both downstream valids are high at the next cycle; R returns to port 0 and B returns to port 3.
- Reset: assert rst during DATA of a 4-beat read after 2 beats. Expected: all outputs are 0 at the next edge; after release, a cpu2 AR is granted first only if cpu0 and cpu1 are idle (pointer=0).
- Stats (AXI_RR_MUX_STATS_EN defined): 3 writes from cpu1 and 2 reads from cpu1. Expected o_grant_cnt[1]=5, all other entries 0.
